// File: rtl/isa_types.sv
// isa_types: shared ISA constants, load FSM states and memory-read bus record.
package isa_types;
   localparam int XLEN = 32;
   localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
   localparam logic [2:0] FUNCT3_SB = 3'b000, FUNCT3_SH = 3'b001, FUNCT3_SW = 3'b010;
   localparam logic [2:0] FUNCT3_LB = 3'b000, FUNCT3_LH = 3'b001, FUNCT3_LW = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100, FUNCT3_LHU = 3'b101;
   typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} load_state_t;
   typedef struct packed {
      logic            rreq;
      logic [XLEN-1:0] raddr;
   } mem_read_t;
   typedef struct packed {
      logic [31:0][XLEN-1:0] xregs;
   } reg_state_t;
   typedef struct packed {
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [4:0]      rs1;
      logic [XLEN-1:0] i_imm_input;
   } decoded_instruction_t;
   function automatic logic is_load_funct3(input logic [2:0] f);
      return f inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
   endfunction
   // halfwords straddle only at offset 3, words at any non-zero offset
   function automatic logic is_split(input logic [2:0] f, input logic [1:0] off);
      return (f[1:0] == 2'b01 && off == 2'b11) || (f == FUNCT3_LW && off != 2'b00);
   endfunction
endpackage

// File: rtl/stage_load_if.sv
// stage_load_if: data-memory read port between the load stage and memory.
interface stage_load_if;
   import isa_types::*;
   logic            mem_rreq;
   logic [XLEN-1:0] mem_raddr;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   modport master (output mem_rreq, output mem_raddr, input mem_rvalid, input mem_rdata);
   modport slave  (input mem_rreq, input mem_raddr, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/stage_load_extract.sv
// load_extract: picks byte/half/word out of {word1, word0} and sign/zero extends it.
module load_extract
   import isa_types::*;
(
   input  logic [XLEN-1:0] word0,
   input  logic [XLEN-1:0] word1,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);
   logic [XLEN-1:0] w;
   logic            sx;
   always_comb begin
      w = XLEN'({word1, word0} >> {offset, 3'b000});
      sx = ~funct3[2];
      result = funct3[1:0] == 2'b00 ? {{(XLEN-8){sx & w[7]}}, w[7:0]} :
               funct3[1:0] == 2'b01 ? {{(XLEN-16){sx & w[15]}}, w[15:0]} : w;
   end
endmodule

// File: rtl/stage_load.sv
// stage_load: load memory stage issuing one or two aligned word reads per load.
module stage_load
   import isa_types::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  reg_state_t           reg_state,
   input  decoded_instruction_t curr_instr,
   output logic                 is_complete,
   output logic [XLEN-1:0]      load_val,
   output logic                 load_fault,
   stage_load_if.master         mem
);
   load_state_t     state;
   mem_read_t       rd;
   logic [1:0]      off;
   logic [2:0]      f3;
   logic [XLEN-1:0] word0, ea_n, ext, x0, x1;
   logic [31:0]     cnt;
   logic            timed_out;
   assign ea_n = curr_instr.i_imm_input + reg_state.xregs[curr_instr.rs1];
   assign mem.mem_rreq = rd.rreq;
   assign mem.mem_raddr = rd.raddr;
   assign timed_out = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1);
   // the final word arrives straight from the bus; only the first half of a split is held
   assign x0 = state == RD1 ? word0 : mem.mem_rdata;
   assign x1 = state == RD1 ? mem.mem_rdata : '0;
   load_extract u_extract (.word0(x0), .word1(x1), .offset(off), .funct3(f3), .result(ext));
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         is_complete <= 1'b0;
         load_val <= '0;
         load_fault <= 1'b0;
         rd <= '0;
         cnt <= '0;
         off <= '0;
         f3 <= '0;
         word0 <= '0;
      end else begin
         is_complete <= 1'b0;
         case (state)
            IDLE: if (enable) begin
               if (curr_instr.opcode != OPCODE_LOAD) begin
                  state <= DONE;
                  is_complete <= 1'b1;
                  load_fault <= 1'b0;
               end else if (!is_load_funct3(curr_instr.funct3)) begin
                  state <= DONE;
                  is_complete <= 1'b1;
                  load_fault <= 1'b1;
                  load_val <= '0;
               end else begin
                  state <= RD0;
                  off <= ea_n[1:0];
                  f3 <= curr_instr.funct3;
                  rd <= '{rreq: 1'b1, raddr: {ea_n[XLEN-1:2], 2'b00}};
                  cnt <= '0;
               end
            end
            RD0, RD1: if (!enable) begin
               state <= IDLE;
               rd.rreq <= 1'b0;
            end else if (mem.mem_rvalid) begin
               cnt <= '0;
               if (state == RD0 && is_split(f3, off)) begin
                  state <= RD1;
                  word0 <= mem.mem_rdata;
                  rd.raddr <= rd.raddr + XLEN'(4);
               end else begin
                  state <= DONE;
                  is_complete <= 1'b1;
                  load_val <= ext;
                  load_fault <= 1'b0;
                  rd.rreq <= 1'b0;
               end
            end else if (timed_out) begin
               state <= DONE;
               is_complete <= 1'b1;
               load_val <= '0;
               load_fault <= 1'b1;
               rd.rreq <= 1'b0;
            end else begin
               cnt <= cnt + 32'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stage_load.sv
// tb_stage_load: directed checks of the load stage against a small latency-programmable memory.
module tb_stage_load;
   import isa_types::*;
   logic clock = 0, reset = 1, enable = 0;
   reg_state_t regs = '0;
   decoded_instruction_t instr = '0;
   logic is_complete, load_fault;
   logic [31:0] load_val;
   int total = 0, bad = 0;
   logic mem_on = 1;
   int wait_cyc = 0, wcnt = 0;
   logic [31:0] a0 = 0, d0 = 0, a1 = 32'hFFFF_FFF0, d1 = 0;
   stage_load_if bus();
   stage_load #(.TIMEOUT_CYCLES(4)) dut (.clock(clock), .reset(reset), .enable(enable),
      .reg_state(regs), .curr_instr(instr), .is_complete(is_complete), .load_val(load_val),
      .load_fault(load_fault), .mem(bus));
   always #5 clock = ~clock;
   always @(posedge clock) wcnt <= (!bus.mem_rreq || bus.mem_rvalid) ? 0 : wcnt + 1;
   assign bus.mem_rvalid = bus.mem_rreq && mem_on && wcnt == wait_cyc;
   assign bus.mem_rdata = bus.mem_raddr == a1 ? d1 : bus.mem_raddr == a0 ? d0 : 32'hBAD0BAD0;

   task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rs1,
                      input logic [31:0] imm, output int lat, output int nreq,
                      output logic [31:0] ra0, output logic [31:0] ra1);
      logic [31:0] last;
      @(negedge clock);
      instr = '{op, f3, rs1, imm};
      enable = 1; lat = -1; nreq = 0; ra0 = 0; ra1 = 0; last = 0;
      for (int c = 1; c <= 50; c++) begin
         @(posedge clock); @(negedge clock);
         if (c == 1) instr.i_imm_input = ~imm;
         if (bus.mem_rreq && (nreq == 0 || bus.mem_raddr != last)) begin
            nreq++; last = bus.mem_raddr;
            if (nreq == 1) ra0 = bus.mem_raddr; else ra1 = bus.mem_raddr;
         end
         if (is_complete) begin lat = c; break; end
      end
      enable = 0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++;
         if ({is_complete, load_fault, bus.mem_rreq, load_val, bus.mem_raddr} !== '0) begin
            bad++; $display("FAIL reset_idle cyc=%0d got c=%b f=%b rq=%b v=%h a=%h want all 0", i,
               is_complete, load_fault, bus.mem_rreq, load_val, bus.mem_raddr);
         end
      end
   endtask

   task automatic test_lw;
      int lat, n; logic [31:0] r0, r1;
      regs.xregs[1] = 32'h100; a0 = 32'h104; d0 = 32'hDEADBEEF; wait_cyc = 0;
      run(OPCODE_LOAD, FUNCT3_LW, 1, 4, lat, n, r0, r1);
      total++; if (r0 !== 32'h104) begin bad++; $display("FAIL lw_addr got=%h exp=104", r0); end
      total++; if (lat !== 2) begin bad++; $display("FAIL lw_lat got=%0d exp=2", lat); end
      total++; if (load_val !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_val got=%h exp=deadbeef", load_val); end
      total++; if (load_fault !== 0) begin bad++; $display("FAIL lw_fault got=%b exp=0", load_fault); end
   endtask

   task automatic test_byte_half;
      int lat, n; logic [31:0] r0, r1;
      logic [2:0] f[5] = '{FUNCT3_LB, FUNCT3_LBU, FUNCT3_LHU, FUNCT3_LH, FUNCT3_LB};
      logic [4:0] rs[5] = '{2, 2, 2, 3, 2};
      logic [31:0] im[5] = '{3, 3, 2, 32'hFFFF_FFFE, 0};
      logic [31:0] ex[5] = '{32'hFFFFFF80, 32'h80, 32'h8011, 32'hFFFF8011, 32'h33};
      regs.xregs[2] = 32'h200; regs.xregs[3] = 32'h204; a0 = 32'h200; d0 = 32'h80112233;
      for (int i = 0; i < 5; i++) begin
         run(OPCODE_LOAD, f[i], rs[i], im[i], lat, n, r0, r1);
         total++;
         if (load_val !== ex[i] || lat !== 2 || r0 !== 32'h200) begin
            bad++; $display("FAIL subword%0d got val=%h lat=%0d addr=%h exp val=%h lat=2 addr=200",
               i, load_val, lat, r0, ex[i]);
         end
      end
   endtask

   task automatic test_split;
      int lat, n; logic [31:0] r0, r1;
      regs.xregs[1] = 32'h3F0; a0 = 32'h3FC; d0 = 32'hAABBCCDD; a1 = 32'h400; d1 = 32'h11223344;
      wait_cyc = 3;
      run(OPCODE_LOAD, FUNCT3_LW, 1, 32'hE, lat, n, r0, r1);
      total++; if (n !== 2 || r0 !== 32'h3FC || r1 !== 32'h400) begin
         bad++; $display("FAIL split_reqs got n=%0d %h %h exp 2 3fc 400", n, r0, r1); end
      total++; if (lat !== 9) begin bad++; $display("FAIL split_lat got=%0d exp=9", lat); end
      total++; if (load_val !== 32'h3344AABB) begin bad++; $display("FAIL split_val got=%h exp=3344aabb", load_val); end
      wait_cyc = 0;
      run(OPCODE_LOAD, FUNCT3_LHU, 1, 32'hF, lat, n, r0, r1);
      total++; if (load_val !== 32'h44AA || lat !== 3 || n !== 2) begin
         bad++; $display("FAIL split_lhu got val=%h lat=%0d n=%0d exp 44aa 3 2", load_val, lat, n); end
      regs.xregs[1] = 32'hFFFF_FFF0; a0 = 32'hFFFF_FFFC; d0 = 32'h01020304; a1 = 0; d1 = 32'h05060708;
      run(OPCODE_LOAD, FUNCT3_LW, 1, 32'hE, lat, n, r0, r1);
      total++; if (load_val !== 32'h07080102 || r1 !== 0 || lat !== 3) begin
         bad++; $display("FAIL split_wrap got val=%h a1=%h lat=%0d exp 07080102 0 3", load_val, r1, lat); end
   endtask

   task automatic test_timeout;
      int lat, n; logic [31:0] r0, r1;
      mem_on = 0;
      run(OPCODE_LOAD, FUNCT3_LW, 1, 32'hC, lat, n, r0, r1);
      mem_on = 1;
      total++; if (lat !== 5) begin bad++; $display("FAIL timeout_lat got=%0d exp=5", lat); end
      total++; if (load_fault !== 1 || load_val !== 0) begin
         bad++; $display("FAIL timeout_res got f=%b v=%h exp f=1 v=0", load_fault, load_val); end
   endtask

   task automatic test_illegal;
      int lat, n; logic [31:0] r0, r1;
      a0 = 32'h100; d0 = 32'h5555AAAA; regs.xregs[1] = 32'h100;
      run(OPCODE_LOAD, FUNCT3_LW, 1, 0, lat, n, r0, r1);
      run(OPCODE_LOAD, 3'b011, 1, 0, lat, n, r0, r1);
      total++; if (lat !== 1 || n !== 0) begin
         bad++; $display("FAIL illegal_lat got lat=%0d reqs=%0d exp 1 0", lat, n); end
      total++; if (load_fault !== 1 || load_val !== 0) begin
         bad++; $display("FAIL illegal_res got f=%b v=%h exp f=1 v=0", load_fault, load_val); end
   endtask

   task automatic test_reset_mid;
      @(negedge clock);
      mem_on = 0; instr = '{OPCODE_LOAD, FUNCT3_LW, 5'd1, 32'h0}; enable = 1;
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 1; enable = 0;
      @(posedge clock); @(negedge clock);
      total++; if ({bus.mem_rreq, bus.mem_raddr, is_complete, load_val} !== '0) begin
         bad++; $display("FAIL reset_mid got rq=%b a=%h c=%b v=%h exp 0", bus.mem_rreq,
            bus.mem_raddr, is_complete, load_val); end
      reset = 0; mem_on = 1;
   endtask

   task automatic test_abort;
      int lat, n, seen; logic [31:0] r0, r1;
      regs.xregs[1] = 32'h100; a0 = 32'h108; d0 = 32'h12345678;
      run(OPCODE_LOAD, FUNCT3_LW, 1, 8, lat, n, r0, r1);
      total++; if (load_val !== 32'h12345678) begin bad++; $display("FAIL abort_pre got=%h exp=12345678", load_val); end
      @(negedge clock);
      mem_on = 0; instr = '{OPCODE_LOAD, FUNCT3_LW, 5'd1, 32'h8}; enable = 1;
      repeat (2) @(posedge clock);
      @(negedge clock); enable = 0;
      @(posedge clock); @(negedge clock);
      total++; if (bus.mem_rreq !== 0) begin bad++; $display("FAIL abort_rreq got=%b exp=0", bus.mem_rreq); end
      mem_on = 1; seen = 0;
      repeat (5) begin @(negedge clock); if (is_complete) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_complete got=%0d exp=0", seen); end
      run(7'b0110011, 3'b000, 1, 0, lat, n, r0, r1);
      total++; if (lat !== 1 || load_val !== 32'h12345678 || load_fault !== 0) begin
         bad++; $display("FAIL nonload got lat=%0d v=%h f=%b exp 1 12345678 0", lat, load_val, load_fault); end
   endtask

   initial begin
      test_reset;
      test_lw;
      test_byte_half;
      test_split;
      test_timeout;
      test_illegal;
      test_reset_mid;
      test_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/stage_load.md
Name: stage_load

Overview:
- Memory-read stage sitting directly upstream of stage_writeback; supplies its load_val input.
- For load instructions, computes the effective address, issues one or two aligned word reads on the data-memory read port, and assembles the result with byte/halfword extraction and sign/zero extension.
- Non-load instructions pass through in one cycle.
- Signals completion to the hart sequencer via is_complete.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_rvalid per access before aborting with load_fault; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  stage active; held high by sequencer until is_complete
- reg_state  in  reg_state_t  architectural registers (rs1 source)
- curr_instr  in  decoded_instruction_t  decoded instruction (opcode, funct3, rs1, i_imm_input)
- is_complete  out  1  one-cycle pulse: stage finished, load_val valid
- load_val  out  XLEN  registered load result, stable until next completion
- load_fault  out  1  with is_complete: illegal funct3 or timeout
- mem_rreq  out  1  read request
- mem_raddr  out  XLEN  word-aligned read address (bits [1:0] = 0)
- mem_rvalid  in  1  read data valid; accepted only while mem_rreq = 1
- mem_rdata  in  XLEN  read data word

Behaviour:
- Reset: state IDLE; is_complete = 0, load_val = 0, load_fault = 0, mem_rreq = 0, mem_raddr = 0; timeout counter cleared.
- FSM states: IDLE, RD0, RD1, DONE.
- IDLE:
  - enable & non-load opcode -> DONE. load_val unchanged, load_fault = 0.
  - enable & load -> latch ea = i_imm_input + xregs[rs1] (mod 2^XLEN), latch funct3, go to RD0.
  - Illegal funct3 (not LB 000, LH 001, LW 010, LBU 100, LHU 101) -> DONE with load_fault = 1, load_val = 0, no memory access.
- RD0:
  - mem_rreq = 1, mem_raddr = {ea[XLEN-1:2], 2'b00}.
  - On mem_rvalid, latch word0.
  - Access is split when (LH/LHU with ea[1:0] = 3) or (LW with ea[1:0] != 0); split -> RD1, else -> DONE.
  - mem_rvalid may arrive in the same cycle mem_rreq rises (zero-wait memory).
- RD1:
  - mem_rreq = 1, mem_raddr = word-aligned ea + 4, wraps at 2^XLEN.
  - On mem_rvalid, latch word1 -> DONE.
- DONE:
  - is_complete = 1 for exactly one cycle; load_val and load_fault registered on entry; mem_rreq = 0.
  - Next state IDLE, regardless of enable.
- Extraction: form {word1, word0} (word1 = 0 if not split), shift right by 8*ea[1:0], take low 8/16/32 bits.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Latency from enable to is_complete:
  - non-load: 1 cycle.
  - aligned load: 2 + memory wait cycles.
  - split load: 3 + wait cycles for both accesses.
- mem_rreq/mem_raddr are registered and stable throughout RD0/RD1. mem_rreq drops the cycle after the final rvalid, or stays high and moves to the second address for a split access.
- Timeout: counter counts cycles in RD0/RD1 without rvalid and resets per access.
  - Reaching TIMEOUT_CYCLES -> DONE with load_fault = 1, load_val = 0.
- enable deasserted in RD0/RD1: abort to IDLE next cycle, no is_complete, mem_rreq = 0. A late rvalid while mem_rreq = 0 is ignored.
- reset mid-operation overrides all and returns to reset values next edge.
- curr_instr/reg_state may change after IDLE; only latched values are used.

Decomposition:
- Shared package isa_types:
  - load funct3 codes (`FUNCT3_LB/LH/LW/LBU/LHU`) alongside the existing SB/SH/SW.
  - load opcode constant.
  - load_state_t enum.
  - mem_read_t struct (rreq, raddr) for reuse by the fetch stage.
- One sub-module: load_extract, a combinational {word1, word0}/offset/funct3 -> XLEN result. It is unit-testable on its own.

Test Plan:
- Reset, then idle: all outputs 0, mem_rreq 0 over 10 cycles.
- LW x1 = 0x100, imm = 4, zero-wait memory returning 0xDEADBEEF at 0x104 -> mem_raddr = 0x104; is_complete 2 cycles after enable; load_val = 0xDEADBEEF, load_fault = 0.
- LB ea = 0x203, word = 0x80112233 -> load_val = 0xFFFFFF80. LBU on the same word -> 0x00000080. LHU ea = 0x202 -> 0x00008011.
- Split LW at ea = 0x3FE, words 0x3FC = 0xAABBCCDD and 0x400 = 0x11223344, with 3-cycle memory wait each -> two requests; load_val = 0x3344AABB; is_complete at cycle 2 + 3 + 3 + 1.
- Memory never responds with TIMEOUT_CYCLES = 4 -> is_complete 1 cycle after 4 wait cycles, load_fault = 1, load_val = 0. Separately, funct3 = 011 -> fault with no mem_rreq.
- enable dropped during RD0 -> no is_complete, mem_rreq low next cycle. A subsequent non-load instruction completes in 1 cycle with load_val unchanged.
